// File: rtl/imem_ctrl.sv
// imem_ctrl: decoupled instruction-memory front end between fetch and decode.
// Credit-limited request issue, stale-response kill after redirect, in-order instr buffer.
module imem_ctrl #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INSN = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_addr,
    input  logic        flush,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic        instr_fault,
    input  logic        dec_ready,
    output logic        fetch_stall
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    state_t        state;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] kill_cnt;
    logic [CW-1:0] buf_cnt;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   buf_data [DEPTH];
    logic          buf_err  [DEPTH];

    logic          credit;
    logic          accept;
    logic          rsp_ok;
    logic          push;
    logic          pop;
    logic          empty;
    logic [CW:0]   used;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        r = p + 1'b1;
        if (p == PW'(DEPTH - 1)) r = '0;
        return r;
    endfunction

    // Credit comes from registered counts only, so a pop frees a slot one cycle later
    assign used          = {1'b0, out_cnt} + {1'b0, buf_cnt};
    assign credit        = used < (CW + 1)'(DEPTH);
    assign mem_req_valid = (state == RUN) && credit;
    assign mem_req_addr  = fetch_addr;
    assign accept        = mem_req_valid && mem_req_ready;
    assign fetch_stall   = !accept;

    assign rsp_ok      = mem_rsp_valid && (out_cnt != '0);
    assign push        = rsp_ok && !flush && (kill_cnt == '0);
    assign empty       = (buf_cnt == '0);
    assign instr_valid = !empty && !flush;
    assign pop         = instr_valid && dec_ready;
    assign instr       = instr_valid ? buf_data[head] : NOP_INSN;
    assign instr_fault = instr_valid && buf_err[head];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            out_cnt  <= '0;
            kill_cnt <= '0;
            buf_cnt  <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            unique case (state)
                IDLE:    state <= RUN;
                RUN:     if (push && mem_rsp_err) state <= HALT;
                HALT:    if (flush) state <= RUN;
                default: state <= IDLE;
            endcase

            out_cnt <= out_cnt + CW'(accept) - CW'(rsp_ok);

            // Everything outstanding at a redirect belongs to the old path
            if (flush) begin
                kill_cnt <= out_cnt - CW'(rsp_ok);
            end else if (rsp_ok && (kill_cnt != '0)) begin
                kill_cnt <= kill_cnt - 1'b1;
            end

            if (flush) begin
                head    <= '0;
                tail    <= '0;
                buf_cnt <= '0;
            end else begin
                if (push) tail <= nxt(tail);
                if (pop)  head <= nxt(head);
                buf_cnt <= buf_cnt + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[tail] <= mem_rsp_err ? NOP_INSN : mem_rsp_data;
            buf_err[tail]  <= mem_rsp_err;
        end
    end

    a_rsp_outstanding: assert property (
        @(posedge clk) disable iff (!rst) mem_rsp_valid |-> (out_cnt != '0));

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst) used <= (CW + 1)'(DEPTH));

    a_kill_bounded: assert property (
        @(posedge clk) disable iff (!rst) kill_cnt <= out_cnt);

endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: table-driven cycles plus scoreboarded memory model for imem_ctrl.
// Directed sequences cover redirect, fault/halt and mid-operation reset.
module tb_imem_ctrl;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] BOOT = 32'h8000080c;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_addr;
    logic        flush;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_fault;
    logic        dec_ready;
    logic        fetch_stall;

    always #5 clk = ~clk;

    imem_ctrl #(.DEPTH(2), .NOP_INSN(NOP)) dut (
        .clk(clk),
        .rst(rst),
        .fetch_addr(fetch_addr),
        .flush(flush),
        .mem_req_valid(mem_req_valid),
        .mem_req_addr(mem_req_addr),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data),
        .mem_rsp_err(mem_rsp_err),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_fault(instr_fault),
        .dec_ready(dec_ready),
        .fetch_stall(fetch_stall)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          live;
    } mreq_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        bit          err;
    } exp_t;

    typedef struct packed {
        bit fl;
        bit drdy;
        bit rrdy;
        bit req;
        bit stall;
        bit iv;
    } vec_t;

    mreq_t       mq[$];
    exp_t        sb[$];
    logic [31:0] pops[$];
    vec_t        tbl [19];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          rsp_n = 0;
    int          err_idx = -1;
    bit          halted = 0;
    bit          saw_fault = 0;
    bit          fl = 0;
    bit          drdy = 1;
    bit          rrdy = 1;
    logic [31:0] pc = BOOT;
    bit          acc;
    logic [31:0] acc_addr;
    bit          s_req;
    bit          s_stall;
    bit          s_iv;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5a5a0f00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_valid"}, {31'b0, mem_req_valid}, 32'd0);
        chk({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
        chk({tag, "_instr"}, instr, NOP);
        chk({tag, "_instr_fault"}, {31'b0, instr_fault}, 32'd0);
        chk({tag, "_fetch_stall"}, {31'b0, fetch_stall}, 32'd1);
    endtask

    // One cycle, entered and left at a falling edge
    task automatic step();
        bit          rv;
        bit          re;
        bit          ev;
        logic [31:0] ra;
        mreq_t       m;
        exp_t        pe;
        rv = 1'b0;
        re = 1'b0;
        ra = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            rv = 1'b1;
            ra = mq[0].addr;
            re = (rsp_n == err_idx);
        end
        mem_rsp_valid = rv;
        mem_rsp_data  = rv ? word_of(ra) : 32'h0;
        mem_rsp_err   = re;
        mem_req_ready = rrdy;
        dec_ready     = drdy;
        flush         = fl;
        fetch_addr    = pc;
        #1;
        s_req    = mem_req_valid;
        s_stall  = fetch_stall;
        s_iv     = instr_valid;
        acc      = mem_req_valid && mem_req_ready;
        acc_addr = mem_req_addr;
        chk("fetch_stall", {31'b0, fetch_stall}, {31'b0, !acc});
        if (mem_req_valid) chk("req_addr", mem_req_addr, pc);
        if (halted) chk("halt_no_req", {31'b0, mem_req_valid}, 32'd0);
        ev = (sb.size() > 0) && !fl;
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, ev});
        chk("instr", instr, ev ? sb[0].word : NOP);
        chk("instr_fault", {31'b0, instr_fault}, {31'b0, ev && sb[0].err});
        if (ev && drdy) begin
            pe = sb.pop_front();
            pops.push_back(pe.addr);
            if (pe.err) saw_fault = 1'b1;
        end
        @(posedge clk);
        if (fl) begin
            sb.delete();
            foreach (mq[i]) mq[i].live = 1'b0;
            halted = 1'b0;
        end
        if (rv) begin
            m = mq.pop_front();
            if (m.live && !fl) begin
                sb.push_back('{m.addr, re ? NOP : word_of(m.addr), re});
                if (re) halted = 1'b1;
            end
            rsp_n++;
        end
        if (acc) begin
            mq.push_back('{acc_addr, cyc + lat, 1'b1});
            pc = pc + 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // fl drdy rrdy | req stall iv
        tbl[0]  = 6'b011_010;
        tbl[1]  = 6'b011_100;
        tbl[2]  = 6'b011_100;
        tbl[3]  = 6'b011_011;
        tbl[4]  = 6'b011_101;
        tbl[5]  = 6'b011_100;
        tbl[6]  = 6'b011_011;
        tbl[7]  = 6'b001_101;
        tbl[8]  = 6'b001_011;
        tbl[9]  = 6'b001_011;
        tbl[10] = 6'b011_011;
        tbl[11] = 6'b001_101;
        tbl[12] = 6'b001_011;
        tbl[13] = 6'b011_011;
        tbl[14] = 6'b011_101;
        tbl[15] = 6'b011_100;
        tbl[16] = 6'b010_011;
        tbl[17] = 6'b010_111;
        tbl[18] = 6'b011_100;

        rst           = 1'b0;
        fetch_addr    = BOOT;
        flush         = 1'b0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_err   = 1'b0;
        dec_ready     = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("reset");

        // Startup, streaming, backpressure and req_ready=0
        rst = 1'b1;
        for (int i = 0; i < 19; i++) begin
            fl   = tbl[i].fl;
            drdy = tbl[i].drdy;
            rrdy = tbl[i].rrdy;
            step();
            chk($sformatf("tbl%0d_req_valid", i), {31'b0, s_req}, {31'b0, tbl[i].req});
            chk($sformatf("tbl%0d_stall", i), {31'b0, s_stall}, {31'b0, tbl[i].stall});
            chk($sformatf("tbl%0d_instr_valid", i), {31'b0, s_iv}, {31'b0, tbl[i].iv});
        end
        chk("stream_n", pops.size(), 32'd8);
        chk("stream_0", pops[0], 32'h8000080c);
        chk("stream_1", pops[1], 32'h80000810);
        chk("stream_2", pops[2], 32'h80000814);

        // Redirect with two requests in flight
        lat  = 4;
        drdy = 1'b1;
        rrdy = 1'b1;
        n    = 0;
        while (mq.size() < 2 && n < 20) begin
            step();
            n++;
        end
        chk("flush_inflight", mq.size(), 32'd2);
        pc = 32'h80000100;
        fl = 1'b1;
        step();
        fl = 1'b0;
        pops.delete();
        n = 0;
        while (pops.size() == 0 && n < 30) begin
            step();
            n++;
        end
        chk("flush_first", pops.size() > 0 ? pops[0] : 32'hx, 32'h80000100);

        // Access fault on the third response from here
        lat     = 1;
        err_idx = rsp_n + 2;
        n       = 0;
        while (!halted && n < 30) begin
            step();
            n++;
        end
        chk("fault_halted", {31'b0, halted}, 32'd1);
        err_idx = -1;
        repeat (6) step();
        chk("fault_popped", {31'b0, saw_fault}, 32'd1);
        pc = 32'h80000200;
        fl = 1'b1;
        step();
        fl = 1'b0;
        step();
        chk("restart_req", {31'b0, acc}, 32'd1);
        chk("restart_addr", acc_addr, 32'h80000200);
        pops.delete();
        repeat (5) step();
        chk("restart_pop", pops.size() > 0 ? pops[0] : 32'hx, 32'h80000200);

        // Reset with requests outstanding and an instruction buffered
        lat  = 3;
        drdy = 1'b0;
        n    = 0;
        while (!(mq.size() >= 1 && sb.size() >= 1) && n < 20) begin
            step();
            n++;
        end
        chk("mid_setup", {31'b0, mq.size() >= 1 && sb.size() >= 1}, 32'd1);
        rst = 1'b0;
        #1;
        chk_reset("mid_reset");
        mq.delete();
        sb.delete();
        halted = 1'b0;
        pc     = BOOT;
        lat    = 1;
        repeat (2) begin
            @(negedge clk);
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hdeadbeef;
        end
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk_reset("late_rsp");
        rst  = 1'b1;
        drdy = 1'b1;
        step();
        chk("reboot_idle", {31'b0, s_req}, 32'd0);
        step();
        chk("reboot_req", {31'b0, acc}, 32'd1);
        chk("reboot_addr", acc_addr, BOOT);
        pops.delete();
        repeat (4) step();
        chk("reboot_pop", pops.size() > 0 ? pops[0] : 32'hx, BOOT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
